// File: rtl/vga_scan_out.sv
// 640x480@60 VGA timing generator that pops monochrome pixels from a FWFT FIFO.
// Optional VGA_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow event counter.
module vga_scan_out #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        active,
  output logic        frame_start,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  typedef enum logic {StSyncWait, StRun} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            active_q, active_d;
  logic            frame_start_q, frame_start_d;
  logic            underflow_q, underflow_d;
  logic [11:0]     rgb_q, rgb_d;

  logic pix_tick, pos_active, at_origin, go, reading, uflow_evt;

  always_comb begin
    pix_tick   = (div_q == DivMax);
    div_d      = pix_tick ? '0 : div_q + 1'b1;
    pos_active = (h_q < 10'd640) && (v_q < 10'd480);
    at_origin  = (h_q == 10'd0) && (v_q == 10'd0);

    h_d = h_q;
    v_d = v_q;
    if (pix_tick) begin
      if (h_q == 10'd799) begin
        h_d = '0;
        v_d = (v_q == 10'd524) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    // The origin pixel that ends SYNC_WAIT is itself consumed.
    go         = (state_q == StSyncWait) && pix_tick && at_origin && !fifo_empty;
    reading    = (state_q == StRun) || go;
    fifo_rd_en = rst && pix_tick && pos_active && reading && !fifo_empty;
    uflow_evt  = pix_tick && pos_active && (state_q == StRun) && fifo_empty;
    state_d    = go ? StRun : state_q;

    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    underflow_d   = underflow_q | uflow_evt;
    if (pix_tick) begin
      hsync_d       = !((h_q >= 10'd656) && (h_q <= 10'd751));
      vsync_d       = !((v_q >= 10'd490) && (v_q <= 10'd491));
      active_d      = pos_active;
      frame_start_d = at_origin;
      if (fifo_rd_en) begin
        rgb_d = fifo_dout ? FG_COLOR : BG_COLOR;
      end else if (uflow_evt) begin
        rgb_d = BG_COLOR;
      end else begin
        rgb_d = 12'h000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StSyncWait;
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      rgb_q         <= rgb_d;
    end
  end

`ifdef VGA_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (uflow_evt && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ucnt_q <= '0;
    else      ucnt_q <= ucnt_d;
  end

  assign underflow_cnt = ucnt_q;
`else
  assign underflow_cnt = 16'h0000;
`endif

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
  assign {red, green, blue} = rgb_q;

endmodule

// File: doc/vga_scan_out.md
VGA_SCAN_OUT -- requirements
Module: vga_scan_out

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, system clocks per pixel (2..16).
REQ-002 SHALL have parameter FG_COLOR, default 12'hFFF, {R,G,B} 4-bit each for pixel value 1.
REQ-003 SHALL have parameter BG_COLOR, default 12'h000, {R,G,B} for pixel value 0.
REQ-004 SHALL have ports:
 - clk  in  1  system clock; all logic rising-edge.
 - rst  in  1  asynchronous, active-low reset.
 - fifo_dout  in  1  monochrome pixel at FIFO head (first-word-fall-through).
 - fifo_empty  in  1  FIFO empty flag.
 - fifo_rd_en  out  1  pop one pixel.
 - hsync  out  1  horizontal sync, active-low.
 - vsync  out  1  vertical sync, active-low.
 - red, green, blue  out  4 each  pixel colour.
 - active  out  1  registered display-enable.
 - frame_start  out  1  one-clk pulse at pixel (0,0).
 - underflow  out  1  sticky underflow flag.
 - underflow_cnt  out  16  underflow event count (see Configuration).

Function
REQ-005 SHALL generate pix_tick: divider 0..CLK_DIV-1, tick high one clk when divider = CLK_DIV-1.
REQ-006 SHALL keep h_cnt 0..799, incrementing on pix_tick, wrapping 799->0 and then incrementing v_cnt 0..524, wrapping 524->0.
REQ-007 SHALL treat position active when h_cnt<640 and v_cnt<480.
REQ-008 SHALL drive hsync low for h_cnt 656..751, vsync low for v_cnt 490..491, else high.
REQ-009 SHALL register hsync, vsync, active, RGB on the pix_tick edge of the sampled position; outputs hold between ticks; latency one clk.
REQ-010 SHALL implement states SYNC_WAIT and RUN; reset enters SYNC_WAIT.
REQ-011 SYNC_WAIT->RUN SHALL occur on the pix_tick where h_cnt=0, v_cnt=0 and fifo_empty=0; that pixel is the first one read.
REQ-012 fifo_rd_en SHALL be combinational: pix_tick & active & (RUN or transition per REQ-011) & !fifo_empty; at most one pop per pixel.
REQ-013 On a pop, output colour SHALL be FG_COLOR if fifo_dout=1, else BG_COLOR.
REQ-014 Outside active, and in SYNC_WAIT, RGB SHALL be 12'h000 and no pop SHALL occur.
REQ-015 In RUN, active pix_tick with fifo_empty=1 SHALL be an underflow: no pop, RGB=BG_COLOR, underflow set, state stays RUN.
REQ-016 underflow SHALL clear only on reset.
REQ-017 frame_start SHALL pulse exactly one clk, registered with REQ-009 outputs, for h_cnt=0,v_cnt=0, in both states.
REQ-018 Sync and counters SHALL run identically in both states, independent of FIFO.

Reset
REQ-019 On rst low, immediately: divider, h_cnt, v_cnt =0; state=SYNC_WAIT; hsync=vsync=1; RGB=0; active=0; frame_start=0; underflow=0; underflow_cnt=0.
REQ-020 Reset mid-frame SHALL abandon frame; after release first pop SHALL occur only at next (0,0) per REQ-011.
REQ-021 fifo_rd_en SHALL be 0 while rst is low.

Configuration
REQ-022 Macro VGA_UNDERFLOW_CNT_EN: defined -> underflow_cnt increments by 1 per REQ-015 event, saturating at 16'hFFFF; undefined -> counter logic absent, underflow_cnt tied 0; underflow flag present in both.

Verification
REQ-023 Reset release, FIFO always non-empty, CLK_DIV=4 -> hsync low 96 pixels (384 clks) per 800-pixel line; vsync low 2 lines per 525-line frame; 307200 pops per frame.
REQ-024 FIFO empty until h_cnt=100,v_cnt=3 of frame 0 -> zero pops in frame 0; first pop at frame 1 (0,0); underflow stays 0.
REQ-025 Pattern alternating 1,0 in RUN -> RGB alternates 12'hFFF,12'h000 each pixel, one clk after each pix_tick.
REQ-026 fifo_empty forced high for 5 active pixels in RUN -> no pops those ticks, RGB=000, underflow=1, underflow_cnt=5 (macro defined) / 0 (undefined).
REQ-027 rst low at h_cnt=320,v_cnt=240 -> outputs to reset values same cycle; after release pops resume only at next (0,0).
REQ-028 Pixel sampled at h_cnt=639 then 640 -> active=1 then 0, pop only at 639, RGB=000 at 640.
